// File: rtl/soundbar_level_ctrl.sv
// Soundbar level controller: turns the raw mic sample stream into a thermometer
// volume code and a colour-scheme select for the pixel renderer. Peak magnitude
// is measured per window and quantised to 0..16. The displayed level attacks
// instantly, then holds, then decays in steps. Level and theme changes are
// committed only on frame_begin, so a frame never tears mid-scan.
//
// state  | meaning
// -------+-------------------------------------------------------------
// HOLD   | level frozen after an attack, hold counter runs down
// DECAY  | level steps down by one every DECAY_FRAMES frames to target
module soundbar_level_ctrl #(
  parameter int SAMPLE_W     = 12,
  parameter int WINDOW       = 4000,
  parameter int HOLD_FRAMES  = 30,
  parameter int DECAY_FRAMES = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                frame_begin,
  input  logic                theme_btn,
  output logic [15:0]         tester,
  output logic [4:0]          level,
  output logic [1:0]          R,
  output logic                window_done
);

  localparam int MW = SAMPLE_W - 1;
  localparam int CW = (WINDOW <= 2) ? 1 : $clog2(WINDOW);
  localparam int HW = (HOLD_FRAMES < 1) ? 1 : $clog2(HOLD_FRAMES + 1);
  localparam int DW = (DECAY_FRAMES <= 1) ? 1 : $clog2(DECAY_FRAMES);

  localparam logic [SAMPLE_W-1:0] MID = {1'b1, {(SAMPLE_W-1){1'b0}}};

  localparam logic [0:0] S_HOLD  = 1'b0;
  localparam logic [0:0] S_DECAY = 1'b1;

  logic [CW-1:0]       win_cnt;
  logic [MW-1:0]       run_max;
  logic [4:0]          target;
  logic [HW-1:0]       hold_cnt;
  logic [DW-1:0]       dec_cnt;
  logic [0:0]          state;
  logic [1:0]          pending;

  logic [SAMPLE_W-1:0] diff;
  logic [MW-1:0]       mag;
  logic [MW-1:0]       max_final;
  logic [4:0]          quant;

  logic [4:0]          lvl_nx;
  logic [HW-1:0]       hold_nx;
  logic [DW-1:0]       dec_nx;
  logic [0:0]          state_nx;

  // Thermometer code: bit i set for every step below the level.
  function automatic logic [15:0] thermo(input logic [4:0] lv);
    logic [15:0] t;
    t = '0;
    for (int i = 0; i < 16; i++) begin
      t[i] = (5'(i) < lv);
    end
    return t;
  endfunction

  // Distance from midpoint; only sample 0 reaches MID, which is clipped to full scale.
  always_comb begin
    diff = '0;
    if (sample >= MID) begin
      diff = sample - MID;
    end else begin
      diff = MID - sample;
    end
    mag = diff[SAMPLE_W-1] ? '1 : diff[MW-1:0];
  end

  // Peak including the current sample, and its 4-bit coarse quantisation plus one.
  always_comb begin
    max_final = (mag > run_max) ? mag : run_max;
    quant     = '0;
    if (max_final != '0) begin
      quant = {1'b0, max_final[MW-1 -: 4]} + 5'd1;
    end
  end

  // Window accumulation; the last window to complete before a frame wins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      win_cnt     <= '0;
      run_max     <= '0;
      target      <= '0;
      window_done <= 1'b0;
    end else begin
      window_done <= 1'b0;
      if (sample_valid) begin
        if (win_cnt == CW'(WINDOW - 1)) begin
          win_cnt     <= '0;
          run_max     <= '0;
          target      <= quant;
          window_done <= 1'b1;
        end else begin
          win_cnt <= win_cnt + CW'(1);
          run_max <= max_final;
        end
      end
    end
  end

  // Frame-rate level FSM; uses the target registered before this edge.
  always_comb begin
    lvl_nx   = level;
    hold_nx  = hold_cnt;
    dec_nx   = dec_cnt;
    state_nx = state;
    if (frame_begin) begin
      if (target > level) begin
        lvl_nx   = target;
        hold_nx  = HW'(HOLD_FRAMES);
        dec_nx   = '0;
        state_nx = S_HOLD;
      end else if (state == S_HOLD) begin
        if (hold_cnt != '0) begin
          hold_nx = hold_cnt - HW'(1);
        end else begin
          state_nx = S_DECAY;
          dec_nx   = '0;
        end
      end else if (target < level) begin
        if (dec_cnt == DW'(DECAY_FRAMES - 1)) begin
          lvl_nx = level - 5'd1;
          dec_nx = '0;
        end else begin
          dec_nx = dec_cnt + DW'(1);
        end
      end else begin
        dec_nx = '0;
      end
    end
  end

  // Level state and its thermometer code commit together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      level    <= '0;
      tester   <= '0;
      hold_cnt <= '0;
      dec_cnt  <= '0;
      state    <= S_HOLD;
    end else begin
      level    <= lvl_nx;
      tester   <= thermo(lvl_nx);
      hold_cnt <= hold_nx;
      dec_cnt  <= dec_nx;
      state    <= state_nx;
    end
  end

  // Theme requests accumulate; R samples the pre-increment value on frame_begin.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending <= '0;
      R       <= '0;
    end else begin
      if (frame_begin) begin
        R <= pending;
      end
      if (theme_btn) begin
        pending <= pending + 2'd1;
      end
    end
  end

endmodule

// File: doc/soundbar_level_ctrl.md
Name: soundbar_level_ctrl

Overview:
Converts the raw microphone sample stream into the 16-bit thermometer volume code and 2-bit colour-scheme select that drive the soundbar pixel renderer. Per measurement window it computes the peak magnitude and quantises it to a level from 0 to 16. It applies instant attack, then hold, then stepped decay. Level and theme changes are committed only on OLED frame boundaries, so a frame never tears mid-scan.

Parameters:
SAMPLE_W, 12, mic sample width (unsigned, midpoint 2^(SAMPLE_W-1))
WINDOW, 4000, valid samples per measurement window (>=2)
HOLD_FRAMES, 30, frames the level is held after an attack before decay starts
DECAY_FRAMES, 8, frames per one-step level decrement during decay (>=1)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
sample_valid  in  1  one-cycle strobe, sample is valid
sample  in  SAMPLE_W  raw unsigned mic sample
frame_begin  in  1  one-cycle pulse at start of OLED frame (pixel index 0)
theme_btn  in  1  debounced one-cycle pulse, request next colour scheme
tester  out  16  thermometer volume code, (1<<level)-1, registered
level  out  5  current displayed level 0..16, registered
R  out  2  colour-scheme select to renderer, registered
window_done  out  1  one-cycle pulse, new target level computed

Behaviour:
- Reset (async, active-high) clears everything:
  - outputs: tester=0, level=0, R=0, window_done=0
  - internal: window count=0, running max=0, target=0, hold count=0, decay count=0, pending theme=0, state=HOLD
- Magnitude: mag = |sample - 2^(SAMPLE_W-1)|. Saturate to 2^(SAMPLE_W-1)-1, so 12-bit gives 0..2047.
- Window: every sample_valid increments the count and updates running max.
  - On the WINDOW-th valid sample (count==WINDOW-1), the final max includes that sample.
  - Quantise the final max: target = 0 if max==0, else max[10:7]+1. Range is 1..16.
  - Same edge: count and running max clear; window_done pulses high the following cycle for exactly one cycle.
  - With sample_valid low there is no count and no max change.
- Frame FSM: evaluated only on cycles with frame_begin=1; all other cycles hold state.
  - Attack, any state, target>level: level<=target, hold<=HOLD_FRAMES, decay<=0, state<=HOLD.
  - HOLD, target<=level, hold!=0: hold<=hold-1.
  - HOLD, target<=level, hold==0: state<=DECAY, decay<=0.
  - DECAY, target<level: decay<=decay+1. When decay==DECAY_FRAMES-1: level<=level-1, decay<=0.
  - DECAY, target==level: stay, level unchanged, decay<=0.
  - Level never drops below target and never exceeds 16.
- tester is updated on the same edge as level, from the new level (16 gives 16'hFFFF, 0 gives 16'h0000). Latency: visible 1 cycle after frame_begin.
- Theme:
  - theme_btn increments the pending theme mod 4 (3 wraps to 0).
  - On frame_begin, R<=pending.
  - theme_btn and frame_begin in the same cycle: R takes the pre-increment pending value; the increment reaches R at the next frame_begin.
- Simultaneous window completion and frame_begin: the FSM uses the old target; the new target takes effect at the next frame_begin.
- A window completing with no intervening frame_begin overwrites target (last window wins).
- Reset mid-window or mid-decay: all state is cleared, and the window restarts from count 0.

Test Plan:
- Reset, then 3 frame_begin pulses, no samples -> tester=16'h0000, level=0, R=0, window_done never asserted.
- WINDOW=4, samples 2048,2048,3000,2048 -> max=952, target=8; window_done pulses one cycle after the 4th sample; next frame_begin gives level=8, tester=16'h00FF.
- WINDOW=4, one sample 0 (mag clipped 2047) -> target=16, tester=16'hFFFF after frame_begin. Then silent windows (target=0), HOLD_FRAMES=2, DECAY_FRAMES=3 -> level stays 16 for 3 frames, then decrements 1 every 3 frames down to 0.
- theme_btn x5 between frames -> R unchanged until frame_begin, then R=1 (5 mod 4).
- theme_btn coincident with frame_begin, pending=2 -> R=2 after that frame, R=3 after the next frame_begin.
- Level 10 in DECAY; async reset asserted mid-cycle between clocks -> tester, level, R clear immediately without waiting for a clock edge. The first window after release needs a full WINDOW samples.
